// File: rtl/accel_pkg.sv
// Shared opcodes, instruction field positions and engine state
// for the grid accelerator.
package accel_pkg;

  localparam int INSTR_W = 24;

  localparam logic [5:0] OP_NOP    = 6'd0;
  localparam logic [5:0] OP_MATMUL = 6'd1;
  localparam logic [5:0] OP_ADD    = 6'd2;

  localparam int OP_MSB = 23;
  localparam int OP_LSB = 18;
  localparam int A_MSB  = 17;
  localparam int A_LSB  = 13;
  localparam int B_MSB  = 12;
  localparam int B_LSB  = 8;
  localparam int D_MSB  = 7;
  localparam int D_LSB  = 3;

  typedef enum logic {
    FETCH,
    EXEC
  } state_t;

endpackage

// File: rtl/grid_row_unit.sv
// One result row: dot products of an A row with B columns, or an
// elementwise row sum. ACCEL_SATURATE_EN clamps instead of wrapping.
module grid_row_unit
  import accel_pkg::*;
#(
  parameter int NUM_SIZE  = 16,
  parameter int GRID_SIZE = 2,
  parameter int RW        = 1
) (
  input  logic                                          mul,
  input  logic [RW-1:0]                                 row,
  input  logic [GRID_SIZE-1:0][NUM_SIZE-1:0]            a_row,
  input  logic [GRID_SIZE*GRID_SIZE-1:0][NUM_SIZE-1:0]  b,
  output logic [GRID_SIZE-1:0][NUM_SIZE-1:0]            d_row
);

  localparam int ACC_W = 2*NUM_SIZE + $clog2(GRID_SIZE);
`ifdef ACCEL_SATURATE_EN
  localparam logic [ACC_W-1:0] MAX = ACC_W'({NUM_SIZE{1'b1}});
`endif

  logic [ACC_W-1:0] acc;

  always_comb begin
    acc   = '0;
    d_row = '0;
    for (int c = 0; c < GRID_SIZE; c++) begin
      acc = '0;
      if (mul) begin
        for (int k = 0; k < GRID_SIZE; k++)
          acc = acc + ACC_W'(a_row[k])
                    * ACC_W'(b[k*GRID_SIZE+c]);
      end else begin
        acc = ACC_W'(a_row[c])
            + ACC_W'(b[int'(row)*GRID_SIZE+c]);
      end
`ifdef ACCEL_SATURATE_EN
      d_row[c] = (acc > MAX) ? {NUM_SIZE{1'b1}}
                             : acc[NUM_SIZE-1:0];
`else
      d_row[c] = acc[NUM_SIZE-1:0];
`endif
    end
  end

endmodule

// File: rtl/grid_accelerator.sv
// Programmable N x N matrix engine over a local word memory.
// Define ACCEL_SATURATE_EN to clamp results instead of wrapping.
module grid_accelerator
  import accel_pkg::*;
#(
  parameter  int NUM_SIZE   = 16,
  parameter  int BUFFER_LEN = 32,
  parameter  int GRID_SIZE  = 2,
  localparam int ADDR_W     = $clog2(BUFFER_LEN)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ce,
  input  logic                mem_we,
  input  logic [ADDR_W-1:0]   mem_addr,
  input  logic [NUM_SIZE-1:0] mem_wdata,
  input  logic                instr_we,
  input  logic [ADDR_W-1:0]   instr_addr,
  input  logic [INSTR_W-1:0]  instr_wdata,
  output logic [ADDR_W-1:0]   pc,
  output logic                busy
);

  localparam int RW = (GRID_SIZE > 1) ? $clog2(GRID_SIZE) : 1;

  logic [NUM_SIZE-1:0] memory       [BUFFER_LEN];
  logic [INSTR_W-1:0]  instructions [BUFFER_LEN];

  state_t              state;
  logic [RW-1:0]       row;
  logic [INSTR_W-1:0]  ins;
  logic [5:0]          op;
  logic [4:0]          ba, bb, bd;
  logic                is_mul, is_op;
  logic                unused_rsvd;
  logic [ADDR_W-1:0]   pc_nxt;

  logic [GRID_SIZE-1:0][NUM_SIZE-1:0]           a_row, d_row;
  logic [GRID_SIZE*GRID_SIZE-1:0][NUM_SIZE-1:0] b_all;

  function automatic logic [ADDR_W-1:0] wrap(
    input int base,
    input int off
  );
    return ADDR_W'((base + off) % BUFFER_LEN);
  endfunction

  always_comb begin
    ins         = instructions[pc];
    op          = ins[OP_MSB:OP_LSB];
    ba          = ins[A_MSB:A_LSB];
    bb          = ins[B_MSB:B_LSB];
    bd          = ins[D_MSB:D_LSB];
    unused_rsvd = ^ins[2:0];
    is_mul      = (op == OP_MATMUL);
    is_op       = is_mul || (op == OP_ADD);
    pc_nxt      = (pc == ADDR_W'(BUFFER_LEN-1))
                ? '0 : pc + 1'b1;
    for (int k = 0; k < GRID_SIZE; k++)
      a_row[k] = memory[wrap(int'(ba),
                             int'(row)*GRID_SIZE + k)];
    for (int i = 0; i < GRID_SIZE*GRID_SIZE; i++)
      b_all[i] = memory[wrap(int'(bb), i)];
  end

  grid_row_unit #(
    .NUM_SIZE  (NUM_SIZE),
    .GRID_SIZE (GRID_SIZE),
    .RW        (RW)
  ) u_row (
    .mul   (is_mul),
    .row   (row),
    .a_row (a_row),
    .b     (b_all),
    .d_row (d_row)
  );

  // Host write is last so it wins over a same-address engine write.
  always_ff @(posedge clk) begin
    if (state == EXEC && ce)
      for (int c = 0; c < GRID_SIZE; c++)
        memory[wrap(int'(bd), int'(row)*GRID_SIZE + c)]
          <= d_row[c];
    if (mem_we)
      memory[mem_addr] <= mem_wdata;
  end

  always_ff @(posedge clk) begin
    if (instr_we)
      instructions[instr_addr] <= instr_wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc    <= '0;
      state <= FETCH;
      row   <= '0;
      busy  <= 1'b0;
    end else if (ce) begin
      unique case (state)
        FETCH: begin
          if (is_op) begin
            state <= EXEC;
            row   <= '0;
            busy  <= 1'b1;
          end else begin
            pc <= pc_nxt;
          end
        end
        EXEC: begin
          if (row == RW'(GRID_SIZE-1)) begin
            state <= FETCH;
            row   <= '0;
            busy  <= 1'b0;
            pc    <= pc_nxt;
          end else begin
            row <= row + 1'b1;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_grid_accelerator.sv
// Scoreboard bench for grid_accelerator: a program-level model queues
// the expected result matrix of every op; a monitor checks on completion.
module tb_grid_accelerator;

  localparam int W  = 16;
  localparam int BL = 32;
  localparam int N  = 2;
  localparam int AW = 5;

  typedef struct packed {
    logic [AW-1:0]             pc_after;
    logic [N*N-1:0][AW-1:0]    addr;
    logic [N*N-1:0][W-1:0]     val;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          ce = 1'b0;
  logic          mem_we = 1'b0;
  logic [AW-1:0] mem_addr = '0;
  logic [W-1:0]  mem_wdata = '0;
  logic          instr_we = 1'b0;
  logic [AW-1:0] instr_addr = '0;
  logic [23:0]   instr_wdata = '0;
  logic [AW-1:0] pc;
  logic          busy;

  always #5 clk = ~clk;

  grid_accelerator #(
    .NUM_SIZE   (W),
    .BUFFER_LEN (BL),
    .GRID_SIZE  (N)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ce          (ce),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .instr_we    (instr_we),
    .instr_addr  (instr_addr),
    .instr_wdata (instr_wdata),
    .pc          (pc),
    .busy        (busy)
  );

  int          passed = 0;
  int          total  = 0;
  logic [W-1:0] mm [BL];
  logic [23:0]  im [BL];
  exp_t        sq [$];
  logic        mon_en = 1'b0;
  logic        pb = 1'b0;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h",
                  name, act, exp);
  endtask

  task automatic mwr(input int a, input logic [W-1:0] d);
    mem_we = 1'b1; mem_addr = AW'(a); mem_wdata = d;
    mm[a] = d;
    @(negedge clk);
    mem_we = 1'b0;
  endtask

  task automatic iwr(input int a, input logic [23:0] d);
    instr_we = 1'b1; instr_addr = AW'(a); instr_wdata = d;
    im[a] = d;
    @(negedge clk);
    instr_we = 1'b0;
  endtask

  function automatic logic [23:0] mk(input int op, input int a,
                                     input int b, input int d);
    return {6'(op), 5'(a), 5'(b), 5'(d), 3'd0};
  endfunction

  function automatic logic [W-1:0] el(input int base, input int off);
    return mm[(base + off) % BL];
  endfunction

  function automatic logic [W-1:0] fit(input longint unsigned s);
`ifdef ACCEL_SATURATE_EN
    if (s > 64'hFFFF) return 16'hFFFF;
`endif
    return W'(s);
  endfunction

  // Computes one row of D from the current model memory, then stores it.
  task automatic exec_row(input logic [23:0] ins, input int r,
                          output logic [N-1:0][W-1:0] v);
    int a, b, d;
    longint unsigned s;
    a = int'(ins[17:13]); b = int'(ins[12:8]); d = int'(ins[7:3]);
    for (int c = 0; c < N; c++) begin
      s = 0;
      if (ins[23:18] == 6'd1) begin
        for (int k = 0; k < N; k++)
          s += 64'(el(a, r*N + k)) * 64'(el(b, k*N + c));
      end else begin
        s = 64'(el(a, r*N + c)) + 64'(el(b, r*N + c));
      end
      v[c] = fit(s);
    end
    for (int c = 0; c < N; c++) mm[(d + r*N + c) % BL] = v[c];
  endtask

  task automatic model_prog();
    exp_t e;
    logic [N-1:0][W-1:0] v;
    for (int p = 0; p < BL; p++) begin
      if (im[p][23:18] == 6'd1 || im[p][23:18] == 6'd2) begin
        e = '0;
        for (int r = 0; r < N; r++) begin
          exec_row(im[p], r, v);
          for (int c = 0; c < N; c++) begin
            e.addr[r*N+c] = AW'((int'(im[p][7:3]) + r*N + c) % BL);
            e.val[r*N+c]  = v[c];
          end
        end
        e.pc_after = AW'((p + 1) % BL);
        sq.push_back(e);
      end
    end
  endtask

  task automatic run_prog(input bit rnd_ce);
    int n;
    rst = 1'b0; ce = 1'b0;
    @(negedge clk);
    check("rst_pc", 32'(pc), 0);
    check("rst_busy", 32'(busy), 0);
    rst = 1'b1;
    model_prog();
    mon_en = 1'b1;
    n = 0;
    while (pc != AW'(20) && n < 3000) begin
      ce = rnd_ce ? ($urandom_range(3) != 0) : 1'b1;
      @(negedge clk);
      n++;
    end
    ce = 1'b0;
    check("pc_reach_timeout", 32'(n < 3000), 1);
    check("sb_drain", 32'(sq.size()), 0);
    mon_en = 1'b0;
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_en && pb && !busy) begin
        if (sq.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          e = sq.pop_front();
          for (int i = 0; i < N*N; i++)
            check($sformatf("mem[%0d]", e.addr[i]),
                  32'(dut.memory[e.addr[i]]), 32'(e.val[i]));
          check("pc_after_op", 32'(pc), 32'(e.pc_after));
        end
      end
      pb = busy;
    end
  end

  initial begin
    logic [N-1:0][W-1:0] v;
    int vals [8] = '{3, 1, 4, 1, 2, 1, 7, 8};
    int r;
    repeat (3) @(negedge clk);
    check("reset_pc", 32'(pc), 0);
    check("reset_busy", 32'(busy), 0);
    for (int p = 0; p < BL; p++) iwr(p, 24'd0);
    for (int i = 0; i < 8; i++) mwr(i, W'(vals[i]));
    for (int i = 8; i < 16; i++) mwr(i, 16'hAAAA);
    iwr(4, mk(1, 0, 4, 8));

    rst = 1'b1;
    repeat (10) @(negedge clk);
    check("ce0_pc", 32'(pc), 0);
    for (int i = 8; i < 12; i++)
      check("ce0_mem", 32'(dut.memory[i]), 32'hAAAA);

    run_prog(1'b0);
    check("mm_d00", 32'(dut.memory[8]), 13);
    check("mm_d01", 32'(dut.memory[9]), 11);
    check("mm_d10", 32'(dut.memory[10]), 15);
    check("mm_d11", 32'(dut.memory[11]), 12);

    iwr(4, 24'd0);
    iwr(0, mk(2, 0, 4, 12));
    run_prog(1'b0);
    check("add_d00", 32'(dut.memory[12]), 5);
    check("add_d01", 32'(dut.memory[13]), 2);
    check("add_d10", 32'(dut.memory[14]), 11);
    check("add_d11", 32'(dut.memory[15]), 9);

    mwr(0, 16'hFFFF); mwr(1, 1); mwr(2, 0); mwr(3, 0);
    mwr(4, 1); mwr(5, 0); mwr(6, 0); mwr(7, 1);
    mwr(12, 2); mwr(13, 0); mwr(14, 0); mwr(15, 0);
    iwr(0, mk(1, 0, 4, 8));
    iwr(1, mk(1, 0, 12, 16));
    run_prog(1'b1);
    check("ident_d00", 32'(dut.memory[8]), 32'hFFFF);
    check("ident_d01", 32'(dut.memory[9]), 1);
`ifdef ACCEL_SATURATE_EN
    check("ovf_d00", 32'(dut.memory[16]), 32'hFFFF);
`else
    check("ovf_d00", 32'(dut.memory[16]), 32'hFFFE);
`endif

    iwr(1, 24'd0);
    mwr(30, 5); mwr(31, 6); mwr(0, 7); mwr(1, 8);
    iwr(0, mk(1, 30, 4, 20));
    run_prog(1'b1);
    for (int i = 0; i < 4; i++)
      check("awrap", 32'(dut.memory[20+i]), 32'(5 + i));

    repeat (4) begin
      for (int i = 0; i < BL; i++)
        mwr(i, ($urandom_range(3) == 0) ? W'($urandom)
                                        : W'($urandom_range(40)));
      for (int p = 0; p < BL; p++) begin
        r = $urandom_range(5);
        if (p >= 16 || r == 0) iwr(p, 24'd0);
        else iwr(p, mk((r < 3) ? 1 : (r < 5) ? 2
                                   : int'($urandom_range(63, 3)),
                       int'($urandom_range(31)),
                       int'($urandom_range(31)),
                       int'($urandom_range(31))));
      end
      run_prog(1'b1);
    end

    for (int p = 0; p < BL; p++)
      iwr(p, (p == 0) ? mk(1, 0, 4, 24) : 24'd0);
    for (int i = 24; i < 28; i++) mwr(i, 16'h5555);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1; ce = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("mid_busy", 32'(busy), 1);
    exec_row(im[0], 0, v);
    rst = 1'b0;
    #1;
    ce = 1'b0;
    check("abort_pc", 32'(pc), 0);
    check("abort_busy", 32'(busy), 0);
    check("abort_row0_c0", 32'(dut.memory[24]), 32'(v[0]));
    check("abort_row0_c1", 32'(dut.memory[25]), 32'(v[1]));
    check("abort_row1_c0", 32'(dut.memory[26]), 32'h5555);
    check("abort_row1_c1", 32'(dut.memory[27]), 32'h5555);
    @(negedge clk);
    rst = 1'b1;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
